// File: rtl/spi_frame_controller_if.sv
// spi_frame_controller_if: host/SPI signal bundle between a frame requester and the SPI frame controller.
interface spi_frame_controller_if #(
  parameter int DATA_WIDTH = 16
);
  logic                  Start;
  logic                  CPOL;
  logic                  CPHA;
  logic [DATA_WIDTH-1:0] TxData;
  logic                  MISO;
  logic                  SClkRaw;
  logic                  S;
  logic                  SS_n;
  logic                  MOSI;
  logic [DATA_WIDTH-1:0] RxData;
  logic                  Busy;
  logic                  Done;
  modport master (
    output Start, CPOL, CPHA, TxData, MISO,
    input  SClkRaw, S, SS_n, MOSI, RxData, Busy, Done
  );
  modport slave (
    input  Start, CPOL, CPHA, TxData, MISO,
    output SClkRaw, S, SS_n, MOSI, RxData, Busy, Done
  );
endinterface

// File: rtl/spi_frame_controller.sv
// spi_frame_controller: SPI master framing FSM (IDLE/SETUP/SHIFT/HOLD/DONE) producing a raw divided
// clock plus an idle control for a downstream glitch-free SCLK gate, with MSB-first full-duplex shifting.
module spi_frame_controller #(
  parameter int DATA_WIDTH = 16,
  parameter int CLK_DIV    = 4
) (
  input logic               Clk,
  input logic               Resetn,
  spi_frame_controller_if.slave bus
);
  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] SETUP = 3'd1;
  localparam logic [2:0] SHIFT = 3'd2;
  localparam logic [2:0] HOLD  = 3'd3;
  localparam logic [2:0] DONE  = 3'd4;
  localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);
  localparam logic [6:0] TOG_LAST = 7'(2 * DATA_WIDTH - 1);
  logic [2:0]            state_q, state_d;
  logic [7:0]            cnt_q, cnt_d;
  logic [6:0]            tog_q, tog_d;
  logic [DATA_WIDTH-1:0] tx_q, tx_d, rxs_q, rxs_d, rx_q, rx_d;
  logic                  sclk_q, sclk_d, cpol_q, cpol_d, cpha_q, cpha_d;
  logic                  div_end, sample;
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    tog_d   = tog_q;
    tx_d    = tx_q;
    rxs_d   = rxs_q;
    rx_d    = rx_q;
    sclk_d  = sclk_q;
    cpol_d  = cpol_q;
    cpha_d  = cpha_q;
    div_end = cnt_q == DIV_LAST;
    // tog_q counts completed toggles, so an even count means the next toggle is a leading edge
    sample  = ~tog_q[0] ^ cpha_q;
    case (state_q)
      IDLE: if (bus.Start) begin
        state_d = SETUP;
        cpol_d  = bus.CPOL;
        cpha_d  = bus.CPHA;
        tx_d    = bus.TxData;
        sclk_d  = bus.CPOL;
        rxs_d   = '0;
      end
      SETUP, HOLD: begin
        cnt_d = div_end ? '0 : cnt_q + 8'd1;
        if (div_end) state_d = (state_q == SETUP) ? SHIFT : DONE;
        if (div_end && state_q == HOLD) rx_d = rxs_q;
      end
      SHIFT: begin
        cnt_d = div_end ? '0 : cnt_q + 8'd1;
        if (div_end) begin
          sclk_d  = ~sclk_q;
          tog_d   = (tog_q == TOG_LAST) ? '0 : tog_q + 7'd1;
          state_d = (tog_q == TOG_LAST) ? HOLD : SHIFT;
          if (sample) rxs_d = {rxs_q[DATA_WIDTH-2:0], bus.MISO};
          else if (cpha_q ? tog_q != '0 : tog_q != TOG_LAST) tx_d = {tx_q[DATA_WIDTH-2:0], 1'b0};
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge Clk or negedge Resetn) begin
    if (!Resetn) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      tog_q   <= '0;
      tx_q    <= '0;
      rxs_q   <= '0;
      rx_q    <= '0;
      sclk_q  <= 1'b0;
      cpol_q  <= 1'b0;
      cpha_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      tog_q   <= tog_d;
      tx_q    <= tx_d;
      rxs_q   <= rxs_d;
      rx_q    <= rx_d;
      sclk_q  <= sclk_d;
      cpol_q  <= cpol_d;
      cpha_q  <= cpha_d;
    end
  end
  assign bus.SClkRaw = sclk_q;
  assign bus.S       = state_q != SHIFT;
  assign bus.SS_n    = state_q == IDLE || state_q == DONE;
  assign bus.MOSI    = (state_q == SETUP || state_q == SHIFT || state_q == HOLD) & tx_q[DATA_WIDTH-1];
  assign bus.RxData  = rx_q;
  assign bus.Busy    = state_q != IDLE;
  assign bus.Done    = state_q == DONE;
endmodule

// File: tb/tb_spi_frame_controller.sv
// tb_spi_frame_controller: directed frames with a queue of expected RxData words, loopback and slave-model MISO.
module tb_spi_frame_controller;
  logic Clk = 1'b0;
  logic Resetn = 1'b0;
  logic loop_en = 1'b1;
  logic cur_cpol = 1'b0;
  logic prev_s = 1'b1;
  logic prev_sclk = 1'b0;
  logic [15:0] slave_word = 16'h0;
  logic [15:0] mosi_cap = 16'h0;
  logic [15:0] exp_q[$];
  int cyc = 0, n_chk = 0, n_fail = 0;
  int done_cnt = 0, ssn_low = 0, tog_cnt = 0, s_bad = 0, hi_run = 0, last_gap = 0;
  int fall_cnt = 0, fall_base = 0;
  int acc, b_done, b_ssn, b_tog, b_sbad, d1, d2, d3;
  spi_frame_controller_if #(.DATA_WIDTH(16)) bus ();
  spi_frame_controller #(.DATA_WIDTH(16), .CLK_DIV(2)) dut (.Clk(Clk), .Resetn(Resetn), .bus(bus));
  always #5 Clk = ~Clk;
  always @(posedge Clk) cyc <= cyc + 1;
  assign bus.MISO = loop_en ? bus.MOSI : slave_word[4'(15 - (fall_cnt - fall_base))];
  always @(negedge bus.SClkRaw) if (!bus.SS_n) fall_cnt <= fall_cnt + 1;
  always @(posedge bus.SClkRaw) if (!bus.SS_n) mosi_cap <= {mosi_cap[14:0], bus.MOSI};
  always @(negedge Clk) begin
    if (bus.Done) done_cnt <= done_cnt + 1;
    if (!bus.SS_n) ssn_low <= ssn_low + 1;
    if (!prev_s && bus.SClkRaw != prev_sclk) tog_cnt <= tog_cnt + 1;
    if (bus.S != prev_s && bus.SClkRaw != cur_cpol) s_bad <= s_bad + 1;
    if (bus.SS_n && !bus.Done) hi_run <= hi_run + 1;
    else if (!bus.SS_n && hi_run != 0) begin
      last_gap <= hi_run;
      hi_run   <= 0;
    end
    prev_s    <= bus.S;
    prev_sclk <= bus.SClkRaw;
  end
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic wait_done(output int at);
    at = -1;
    for (int k = 0; k < 300; k++) begin
      @(negedge Clk);
      if (bus.Done) begin
        at = cyc;
        break;
      end
    end
    if (at < 0) check("done_timeout", 0, 1);
  endtask
  task automatic pop_rx(input string tag);
    if (exp_q.size() == 0) check({tag, "_queue_empty"}, 0, 1);
    else check(tag, bus.RxData, exp_q.pop_front());
  endtask
  task automatic start_frame(input logic cp, input logic ch, input logic [15:0] tx, input logic [15:0] exp);
    @(negedge Clk);
    bus.CPOL = cp;
    bus.CPHA = ch;
    bus.TxData = tx;
    cur_cpol = cp;
    bus.Start = 1'b1;
    exp_q.push_back(exp);
    @(posedge Clk);
    #1;
    acc = cyc;
    bus.Start = 1'b0;
    b_done = done_cnt;
    b_ssn = ssn_low;
    b_tog = tog_cnt;
    b_sbad = s_bad;
  endtask
  task automatic finish_frame();
    int at;
    wait_done(at);
    if (at >= 0) begin
      check("latency", at - acc + 1, 69);
      pop_rx("rxdata");
    end
    repeat (2) @(negedge Clk);
    check("ssn_low_cycles", ssn_low - b_ssn, 68);
    check("sclk_toggles", tog_cnt - b_tog, 32);
    check("s_change_off_idle", s_bad - b_sbad, 0);
    check("idle_sclk", bus.SClkRaw, cur_cpol);
    check("idle_mosi", bus.MOSI, 0);
    check("idle_busy", bus.Busy, 0);
    check("idle_ssn", bus.SS_n, 1);
    check("done_pulses", done_cnt - b_done, 1);
  endtask
  initial begin
    bus.Start = 1'b0;
    bus.CPOL = 1'b0;
    bus.CPHA = 1'b0;
    bus.TxData = 16'h0;
    #2;
    check("rst_ssn", bus.SS_n, 1);
    check("rst_s", bus.S, 1);
    check("rst_sclk", bus.SClkRaw, 0);
    check("rst_mosi", bus.MOSI, 0);
    check("rst_rx", bus.RxData, 0);
    check("rst_busy", bus.Busy, 0);
    check("rst_done", bus.Done, 0);
    @(negedge Clk);
    Resetn = 1'b1;
    repeat (2) @(negedge Clk);
    start_frame(1'b0, 1'b0, 16'hA5C3, 16'hA5C3);
    repeat (2) @(negedge Clk);
    check("busy_in_frame", bus.Busy, 1);
    check("s_high_in_setup", bus.S, 1);
    finish_frame();
    loop_en = 1'b0;
    slave_word = 16'h8001;
    fall_base = fall_cnt;
    start_frame(1'b0, 1'b0, 16'hFFFF, 16'h8001);
    finish_frame();
    check("mosi_stream", mosi_cap, 16'hFFFF);
    loop_en = 1'b1;
    start_frame(1'b0, 1'b1, 16'h5A3C, 16'h5A3C);
    finish_frame();
    start_frame(1'b1, 1'b0, 16'h5A3C, 16'h5A3C);
    finish_frame();
    start_frame(1'b1, 1'b1, 16'h5A3C, 16'h5A3C);
    finish_frame();
    start_frame(1'b0, 1'b0, 16'h3C96, 16'h3C96);
    repeat (8) @(negedge Clk);
    bus.Start = 1'b1;
    bus.TxData = 16'hFFFF;
    bus.CPHA = 1'b1;
    @(negedge Clk);
    bus.Start = 1'b0;
    check("busy_mid", bus.Busy, 1);
    repeat (29) @(negedge Clk);
    bus.Start = 1'b1;
    bus.CPOL = 1'b1;
    @(negedge Clk);
    bus.Start = 1'b0;
    finish_frame();
    repeat (100) @(negedge Clk);
    check("no_queued_frame", done_cnt - b_done, 1);
    check("rx_held", bus.RxData, 16'h3C96);
    start_frame(1'b0, 1'b0, 16'h0F0F, 16'h0F0F);
    repeat (29) @(negedge Clk);
    #2;
    Resetn = 1'b0;
    #1;
    check("abort_ssn", bus.SS_n, 1);
    check("abort_s", bus.S, 1);
    check("abort_busy", bus.Busy, 0);
    check("abort_sclk", bus.SClkRaw, 0);
    check("abort_rx", bus.RxData, 0);
    void'(exp_q.pop_back());
    @(negedge Clk);
    Resetn = 1'b1;
    repeat (100) @(negedge Clk);
    check("no_done_after_abort", done_cnt - b_done, 0);
    start_frame(1'b0, 1'b0, 16'h1234, 16'h1234);
    finish_frame();
    @(negedge Clk);
    bus.CPOL = 1'b0;
    bus.CPHA = 1'b0;
    bus.TxData = 16'hC33C;
    cur_cpol = 1'b0;
    bus.Start = 1'b1;
    repeat (3) exp_q.push_back(16'hC33C);
    @(posedge Clk);
    #1;
    acc = cyc;
    b_done = done_cnt;
    wait_done(d1);
    check("b2b_latency", d1 - acc + 1, 69);
    pop_rx("b2b_rx1");
    wait_done(d2);
    check("b2b_period12", d2 - d1, 70);
    check("b2b_gap12", last_gap, 1);
    pop_rx("b2b_rx2");
    wait_done(d3);
    bus.Start = 1'b0;
    check("b2b_period23", d3 - d2, 70);
    check("b2b_gap23", last_gap, 1);
    pop_rx("b2b_rx3");
    repeat (80) @(negedge Clk);
    check("b2b_done_pulses", done_cnt - b_done, 3);
    check("queue_drained", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/spi_frame_controller.md
SPI_FRAME_CONTROLLER -- requirements
Module: spi_frame_controller

Interface
REQ-001 Parameter DATA_WIDTH, default 16: bits per SPI frame, range 2..32.
REQ-002 Parameter CLK_DIV, default 4: system clocks per SCLK half-period, range 1..255.
REQ-003 Clk  input  1  system clock; all state updates on the rising edge.
REQ-004 Resetn  input  1  asynchronous, active-low reset.
REQ-005 Start  input  1  frame request, sampled only in IDLE.
REQ-006 CPOL  input  1  SPI clock polarity, captured on an accepted Start.
REQ-007 CPHA  input  1  SPI clock phase, captured on an accepted Start.
REQ-008 TxData  input  DATA_WIDTH  word to transmit, captured on an accepted Start.
REQ-009 MISO  input  1  serial data from the slave, treated as synchronous to Clk.
REQ-010 SClkRaw  output  1  divided clock to the downstream SCLK gating stage (its Clk input).
REQ-011 S  output  1  idle control to the downstream SCLK gating stage; 1 = idle, 0 = pass SClkRaw.
REQ-012 SS_n  output  1  active-low slave select.
REQ-013 MOSI  output  1  serial data to the slave, MSB first.
REQ-014 RxData  output  DATA_WIDTH  last received word, MSB first.
REQ-015 Busy  output  1  high from the cycle after an accepted Start through the Done cycle.
REQ-016 Done  output  1  one-cycle pulse at frame completion.

Function
REQ-017 The FSM SHALL have the states IDLE, SETUP, SHIFT, HOLD and DONE, with no other reachable states.
REQ-018 IDLE: when Start=1, the block SHALL capture CPOL, CPHA and TxData, then go to SETUP; otherwise it SHALL stay in IDLE.
REQ-019 SETUP SHALL last exactly CLK_DIV cycles: SS_n=0, S=1, SClkRaw=CPOL, MOSI=TxData MSB; then go to SHIFT.
REQ-020 SHIFT SHALL last exactly 2*DATA_WIDTH*CLK_DIV cycles with S=0.
- SClkRaw toggles every CLK_DIV cycles: 2*DATA_WIDTH toggles total.
- SClkRaw equals CPOL on exit from SHIFT.
REQ-021 Leading edge = odd-numbered toggle; trailing edge = even-numbered toggle.
- CPHA=0: sample MISO on leading edges; advance MOSI on trailing edges, except the last.
- CPHA=1: advance MOSI on leading edges (the first leading edge presents the MSB); sample MISO on trailing edges.
REQ-022 Sampling SHALL use the MISO value present in the cycle the toggle is registered. Exactly DATA_WIDTH samples are taken, shifted in MSB first.
REQ-023 HOLD SHALL last exactly CLK_DIV cycles (SS_n=0, S=1, SClkRaw=CPOL), then go to DONE.
REQ-024 DONE SHALL last one cycle: Done=1, RxData updated with the assembled word in that same cycle, SS_n=1; then go to IDLE.
REQ-025 Start outside IDLE SHALL be ignored and SHALL NOT be queued.
- Changes to CPOL, CPHA or TxData mid-frame SHALL have no effect.
REQ-026 Done SHALL be high exactly (2*DATA_WIDTH+2)*CLK_DIV+1 cycles after the edge at which Start was accepted.
REQ-027 Back-to-back frames: Start=1 held high SHALL begin the next frame the cycle after DONE, with SS_n high for exactly one cycle (the IDLE cycle).
REQ-028 In IDLE the outputs SHALL be: S=1, SS_n=1, SClkRaw=last captured CPOL, MOSI=0, and the divider counter held at 0.
REQ-029 RxData SHALL hold its value between frames and change only in DONE.
REQ-030 S SHALL change only while SClkRaw equals the captured CPOL, so the gated SCLK never glitches.

Reset
REQ-031 Resetn=0 SHALL immediately set the following, regardless of Clk:
- FSM = IDLE
- SS_n=1, S=1, SClkRaw=0, MOSI=0
- RxData=0, Busy=0, Done=0
- divider and bit counters = 0
- captured CPOL/CPHA = 0
REQ-032 Reset during any state SHALL abort the frame. No Done is produced, and the first Start after release SHALL run a complete frame normally.

Verification
REQ-033 DATA_WIDTH=16, CLK_DIV=2, CPOL=0, CPHA=0, MOSI looped to MISO, TxData=0xA5C3, one-cycle Start -> Done at cycle 69, RxData=0xA5C3, SS_n low for cycles 1..68, 32 SClkRaw toggles with S=0.
REQ-034 Same loopback in modes (CPOL,CPHA) = (0,1), (1,0), (1,1) with TxData=0x5A3C -> RxData=0x5A3C. SClkRaw idles at 1 for CPOL=1, and S is never 0 while SClkRaw is at its idle level outside SHIFT.
REQ-035 MISO driven from a slave model returning 0x8001, TxData=0xFFFF, mode (0,0) -> RxData=0x8001. The MOSI stream captured at leading edges equals 0xFFFF.
REQ-036 Start pulsed at cycles 10 and 40 of an active frame, and TxData changed mid-frame -> no extra frame, transmitted word unchanged, exactly one Done.
REQ-037 Resetn pulsed low at cycle 30 of a frame -> SS_n=1 and S=1 within the reset assertion, no Done. A following Start with TxData=0x1234 in loopback -> RxData=0x1234.
REQ-038 Start held high for 3 frames -> three Done pulses 70 cycles apart, and SS_n high for exactly one cycle between frames.
